// File: rtl/viterbi_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// viterbi_frame_sequencer_if
//   Bundle of every signal between the frame sequencer and its neighbours:
//   table-config stream, encoded-symbol stream, Viterbi core side and the
//   decoded-result stream, plus the status outputs.
//
//   modport master : the sequencer itself (drives cfg_ready, sym_ready,
//                    dec_*, out_*, frame_count, tables_valid)
//   modport slave  : the environment (config source, symbol source, core,
//                    result consumer)
//
//   Parameters: N encoded bits/symbol, K input bits/step, M constraint length,
//               L symbols/frame, E error-count MSB index.
// ----------------------------------------------------------------------------
interface viterbi_frame_sequencer_if #(
    parameter int N = 2,
    parameter int K = 1,
    parameter int M = 4,
    parameter int L = 7,
    parameter int E = $clog2(L * N)
);
    // table configuration stream
    logic             cfg_valid;
    logic             cfg_ready;
    logic [M-K-1:0]   cfg_state;
    logic [K-1:0]     cfg_input;
    logic [M-K-1:0]   cfg_next;
    logic [N-1:0]     cfg_out;
    logic             reconfig;

    // encoded symbol stream
    logic             sym_valid;
    logic             sym_ready;
    logic [N-1:0]     sym_data;
    logic [E:0]       err_limit;

    // decoder core side
    logic             dec_load;
    logic [M-K-1:0]   dec_state_address;
    logic [K-1:0]     dec_input_address;
    logic [M-K-1:0]   dec_next_state_data;
    logic [N-1:0]     dec_output_data;
    logic             dec_restart;
    logic             dec_enable;
    logic [N-1:0]     dec_encoded;
    logic             dec_ready;
    logic [L*K-1:0]   dec_decoded;
    logic [E:0]       dec_error;

    // result stream and status
    logic             out_valid;
    logic             out_ready;
    logic [L*K-1:0]   out_decoded;
    logic [E:0]       out_error;
    logic             out_uncorr;
    logic             out_timeout;
    logic [15:0]      frame_count;
    logic             tables_valid;

    modport master (
        input  cfg_valid, cfg_state, cfg_input, cfg_next, cfg_out, reconfig,
               sym_valid, sym_data, err_limit, dec_ready, dec_decoded,
               dec_error, out_ready,
        output cfg_ready, sym_ready, dec_load, dec_state_address,
               dec_input_address, dec_next_state_data, dec_output_data,
               dec_restart, dec_enable, dec_encoded, out_valid, out_decoded,
               out_error, out_uncorr, out_timeout, frame_count, tables_valid
    );

    modport slave (
        output cfg_valid, cfg_state, cfg_input, cfg_next, cfg_out, reconfig,
               sym_valid, sym_data, err_limit, dec_ready, dec_decoded,
               dec_error, out_ready,
        input  cfg_ready, sym_ready, dec_load, dec_state_address,
               dec_input_address, dec_next_state_data, dec_output_data,
               dec_restart, dec_enable, dec_encoded, out_valid, out_decoded,
               out_error, out_uncorr, out_timeout, frame_count, tables_valid
    );
endinterface

// File: rtl/viterbi_frame_sequencer.sv
// ----------------------------------------------------------------------------
// viterbi_frame_sequencer
//   Front-end controller for a Viterbi decoder core. Loads the core's
//   next-state/output tables from the cfg stream (2**M beats), buffers one
//   L-symbol frame, restarts the core, streams the frame gap-free on L
//   cycles, waits (bounded by TMO cycles) for the core's ready and offers the
//   decoded bits, error count and flags on a valid/ready result port.
//
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset (all outputs 0, dec_restart 1)
//     bus      viterbi_frame_sequencer_if.master: cfg_*, reconfig, sym_*,
//              err_limit, dec_*, out_*, frame_count, tables_valid
// ----------------------------------------------------------------------------
module viterbi_frame_sequencer #(
    parameter int N   = 2,
    parameter int K   = 1,
    parameter int M   = 4,
    parameter int L   = 7,
    parameter int E   = $clog2(L * N),
    parameter int TMO = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    viterbi_frame_sequencer_if.master bus
);
    localparam int ENTRIES = 2 ** M;
    localparam int IW      = (L > 1) ? $clog2(L) : 1;
    localparam int TW      = $clog2(TMO + 1);

    localparam logic [M-1:0]  LAST_ENTRY = M'(ENTRIES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(L - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO - 1);

    typedef enum logic [2:0] {
        S_CFG, S_COLLECT, S_RESTART, S_FEED, S_WAIT, S_OUTPUT
    } state_t;

    state_t           state_q, state_d;
    logic [M-1:0]     entry_q, entry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [L*K-1:0]   decoded_q, decoded_d;
    logic [E:0]       error_q, error_d;
    logic             uncorr_q, uncorr_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             tables_valid_q, tables_valid_d;
    logic [N-1:0]     sym_buf_q [L];

    logic cfg_rdy, sym_rdy, reconfig_take;
    logic cfg_fire, sym_fire, out_fire;

    // cfg_ready is masked by reset so every handshake output reads 0 while
    // reset_n is low, even though the reset state is CFG.
    assign cfg_rdy       = (state_q == S_CFG) && reset_n;
    // reconfig only takes effect between frames; it then blocks the symbol.
    assign reconfig_take = (state_q == S_COLLECT) && bus.reconfig && (idx_q == '0);
    assign sym_rdy       = (state_q == S_COLLECT) && !reconfig_take;
    assign cfg_fire      = cfg_rdy && bus.cfg_valid;
    assign sym_fire      = sym_rdy && bus.sym_valid;
    assign out_fire      = (state_q == S_OUTPUT) && bus.out_ready;

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_CFG;
            entry_q        <= '0;
            idx_q          <= '0;
            tmo_q          <= '0;
            decoded_q      <= '0;
            error_q        <= '0;
            uncorr_q       <= 1'b0;
            timeout_q      <= 1'b0;
            frame_count_q  <= '0;
            tables_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            decoded_q      <= decoded_d;
            error_q        <= error_d;
            uncorr_q       <= uncorr_d;
            timeout_q      <= timeout_d;
            frame_count_q  <= frame_count_d;
            tables_valid_q <= tables_valid_d;
        end
    end

    // NOTE: the symbol buffer has no reset; it is always fully rewritten
    // before FEED reads it, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (sym_fire) begin
            sym_buf_q[idx_q] <= bus.sym_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a hold default first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        idx_d          = idx_q;
        tmo_d          = tmo_q;
        decoded_d      = decoded_q;
        error_d        = error_q;
        uncorr_d       = uncorr_q;
        timeout_d      = timeout_q;
        frame_count_d  = frame_count_q;
        tables_valid_d = tables_valid_q;

        unique case (state_q)
            S_CFG: begin
                // Beats are counted, not addresses; the 2**M-th beat completes the load.
                if (cfg_fire) begin
                    entry_d = entry_q + 1'b1;
                    if (entry_q == LAST_ENTRY) begin
                        tables_valid_d = 1'b1;
                        state_d        = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (reconfig_take) begin
                    entry_d        = '0;
                    tables_valid_d = 1'b0;
                    state_d        = S_CFG;
                end else if (sym_fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_RESTART;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RESTART: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.dec_ready) begin
                    decoded_d = bus.dec_decoded;
                    error_d   = bus.dec_error;
                    uncorr_d  = (bus.dec_error > bus.err_limit);
                    timeout_d = 1'b0;
                    state_d   = S_OUTPUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    // This cycle brings the count to TMO: give up on the core.
                    if (tmo_q == TMO_LAST) begin
                        decoded_d = '0;
                        error_d   = '1;
                        uncorr_d  = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                if (out_fire) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = S_COLLECT;
                end
            end
            default: state_d = S_CFG;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.cfg_ready           = cfg_rdy;
        bus.sym_ready           = sym_rdy;
        // Table writes pass straight through to the core in the handshake cycle.
        bus.dec_load            = cfg_fire;
        bus.dec_state_address   = cfg_fire ? bus.cfg_state : '0;
        bus.dec_input_address   = cfg_fire ? bus.cfg_input : '0;
        bus.dec_next_state_data = cfg_fire ? bus.cfg_next  : '0;
        bus.dec_output_data     = cfg_fire ? bus.cfg_out   : '0;
        // The core runs only while fed or being waited on; otherwise held in restart.
        bus.dec_enable          = (state_q == S_FEED) || (state_q == S_WAIT);
        bus.dec_restart         = !bus.dec_enable;
        bus.dec_encoded         = (state_q == S_FEED) ? sym_buf_q[idx_q] : '0;
        bus.out_valid           = (state_q == S_OUTPUT);
        bus.out_decoded         = decoded_q;
        bus.out_error           = error_q;
        bus.out_uncorr          = uncorr_q;
        bus.out_timeout         = timeout_q;
        bus.frame_count         = frame_count_q;
        bus.tables_valid        = tables_valid_q;
    end
endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
module tb_viterbi_frame_sequencer;
    localparam int N   = 2;
    localparam int K   = 1;
    localparam int M   = 4;
    localparam int L   = 7;
    localparam int E   = $clog2(L * N);
    localparam int TMO = 4;
    localparam int SW  = M - K;
    localparam int NE  = 2 ** M;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fexp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    viterbi_frame_sequencer_if #(.N(N), .K(K), .M(M), .L(L), .E(E)) bus ();

    viterbi_frame_sequencer #(.N(N), .K(K), .M(M), .L(L), .E(E), .TMO(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Intended trellis: rate-1/2, constraint length 4, generators 1111 / 1101.
    logic [SW-1:0] ref_next [NE];
    logic [N-1:0]  ref_out  [NE];
    logic [N-1:0]  tx [L];

    // ---------------- behavioural decoder core ----------------
    logic [SW-1:0] core_next [NE];
    logic [N-1:0]  core_out  [NE];
    logic [N-1:0]  rx [L];
    int            core_lat = 1;
    int            ncap = 0;
    int            since = -1;
    logic [L-1:0]  core_best;
    int            core_dist;

    // Maximum-likelihood search over every possible input frame (start state 0).
    function automatic void ml_decode(output logic [L-1:0] best, output int bestd);
        bestd = 1 << 20;
        best  = '0;
        for (int c = 0; c < (1 << L); c++) begin
            int d = 0;
            int s = 0;
            for (int j = 0; j < L; j++) begin
                int u = (c >> (L - 1 - j)) & 1;
                int e = s * 2 + u;
                d += $countones(core_out[e] ^ rx[j]);
                s = int'(core_next[e]);
            end
            if (d < bestd) begin
                bestd = d;
                best  = L'(c);
            end
        end
    endfunction

    // The core raises ready on the core_lat-th cycle after its L-th symbol.
    always @(negedge clk) begin
        if (bus.dec_load) begin
            core_next[{bus.dec_state_address, bus.dec_input_address}] = bus.dec_next_state_data;
            core_out[{bus.dec_state_address, bus.dec_input_address}]  = bus.dec_output_data;
        end
        if (bus.dec_restart) begin
            ncap = 0;
            since = -1;
            bus.dec_ready = 1'b0;
        end else if (bus.dec_enable) begin
            if (ncap < L) begin
                rx[ncap] = bus.dec_encoded;
                ncap++;
                if (ncap == L) since = 0;
            end else if (since >= 0) begin
                since++;
                if (since == core_lat) begin
                    ml_decode(core_best, core_dist);
                    bus.dec_decoded = core_best;
                    bus.dec_error   = (E + 1)'(core_dist);
                    bus.dec_ready   = 1'b1;
                    since = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic build_ref_tables();
        for (int s = 0; s < NE / 2; s++) begin
            for (int u = 0; u < 2; u++) begin
                logic [3:0] r;
                r = {1'(u), 3'(s)};
                ref_next[s * 2 + u] = SW'(r[3:1]);
                ref_out[s * 2 + u]  = {^(r & 4'b1111), ^(r & 4'b1101)};
            end
        end
    endtask

    task automatic encode(input logic [L-1:0] bits, input int flip);
        int s = 0;
        for (int j = 0; j < L; j++) begin
            int e = s * 2 + int'(bits[L - 1 - j]);
            tx[j] = ref_out[e];
            s = int'(ref_next[e]);
        end
        if (flip >= 0) tx[flip / N][flip % N] = ~tx[flip / N][flip % N];
    endtask

    task automatic program_tables();
        bit bad = 0;
        bus.cfg_valid = 1'b1;
        for (int e = 0; e < NE; e++) begin
            bus.cfg_state = SW'(e >> 1);
            bus.cfg_input = 1'(e & 1);
            bus.cfg_next  = ref_next[e];
            bus.cfg_out   = ref_out[e];
            @(negedge clk);
            checks++;
            if ({bus.cfg_ready, bus.dec_load, bus.dec_state_address, bus.dec_input_address,
                 bus.dec_next_state_data, bus.dec_output_data} !==
                {2'b11, SW'(e >> 1), 1'(e & 1), ref_next[e], ref_out[e]}) begin
                errors++;
                $display("FAIL cfg_beat %0d: ready=%0b load=%0b st=%0h in=%0h nx=%0h out=%0h",
                         e, bus.cfg_ready, bus.dec_load, bus.dec_state_address,
                         bus.dec_input_address, bus.dec_next_state_data, bus.dec_output_data);
            end
            checks++;
            if (bus.tables_valid !== 1'b0) begin
                errors++;
                $display("FAIL tables_valid_early beat %0d: got %0b expected 0", e, bus.tables_valid);
            end
            @(posedge clk); #1;
        end
        bus.cfg_valid = 1'b0;
        checks++;
        if ({bus.tables_valid, bus.cfg_ready, bus.sym_ready} !== 3'b101) begin
            errors++;
            $display("FAIL cfg_done: tables_valid/cfg_ready/sym_ready got %b expected 101",
                     {bus.tables_valid, bus.cfg_ready, bus.sym_ready});
        end
        for (int e = 0; e < NE; e++)
            if (core_next[e] !== ref_next[e] || core_out[e] !== ref_out[e]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL core_tables: table seen by core got differs expected reference table");
        end
    endtask

    task automatic send_frame(input logic [L-1:0] bits, input int flip, input int rc_at,
                              output int hs_cyc);
        int first_cyc = -1;
        hs_cyc = -1;
        encode(bits, flip);
        for (int i = 0; i < L; i++) begin
            bit ok = 0;
            bus.sym_valid = 1'b1;
            bus.sym_data  = tx[i];
            bus.reconfig  = (i == rc_at);
            for (int w = 0; w < 20 && !ok; w++) begin
                @(negedge clk);
                if (bus.sym_ready) begin
                    ok = 1;
                    hs_cyc = cyc;
                    if (i == 0) first_cyc = cyc;
                end
                @(posedge clk); #1;
            end
            bus.reconfig = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sym_accept: symbol %0d got no handshake expected within 20 cycles", i);
            end
        end
        bus.sym_valid = 1'b0;
        checks++;
        if (hs_cyc - first_cyc !== L - 1) begin
            errors++;
            $display("FAIL back_to_back: span got %0d expected %0d", hs_cyc - first_cyc, L - 1);
        end
    endtask

    // One complete frame: send, time the result, check fields, hold, accept.
    task automatic run_frame(input logic [L-1:0] bits, input int flip, input int lim,
                             input int lat, input int hold, input int rc_at);
        int hs, w, low, vcyc;
        bit sym_seen, load_seen;
        logic [L-1:0] ed;
        logic [E:0]   ee;
        logic         eu, et;
        bus.err_limit = (E + 1)'(lim);
        core_lat = lat;
        if (lat <= TMO) begin
            w  = lat;
            ed = bits;
            ee = (E + 1)'((flip >= 0) ? 1 : 0);
            eu = (int'(ee) > lim);
            et = 1'b0;
        end else begin
            w  = TMO;
            ed = '0;
            ee = '1;
            eu = 1'b1;
            et = 1'b1;
        end
        send_frame(bits, flip, rc_at, hs);
        low = 0; vcyc = -1; sym_seen = 0; load_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.dec_restart) low++;
            if (bus.sym_ready) sym_seen = 1;
            if (bus.dec_load || bus.cfg_ready) load_seen = 1;
            if (bus.out_valid) begin
                vcyc = cyc;
                break;
            end
            @(posedge clk);
        end
        checks++;
        if (vcyc !== hs + L + 2 + w) begin
            errors++;
            $display("FAIL out_valid_cycle: got %0d expected %0d", vcyc - hs, L + 2 + w);
        end
        checks++;
        if (low !== L + w) begin
            errors++;
            $display("FAIL restart_low_cycles: got %0d expected %0d", low, L + w);
        end
        checks++;
        if (sym_seen || load_seen) begin
            errors++;
            $display("FAIL busy_handshakes: sym_ready seen %0b cfg/load seen %0b expected 0 0",
                     sym_seen, load_seen);
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            checks++;
            if ({bus.out_valid, bus.sym_ready, bus.out_decoded, bus.out_error, bus.out_uncorr,
                 bus.out_timeout} !== {2'b10, ed, ee, eu, et}) begin
                errors++;
                $display("FAIL result hold %0d: valid=%0b symrdy=%0b dec=%b err=%0d unc=%0b tmo=%0b expected 1 0 %b %0d %0b %0b",
                         h, bus.out_valid, bus.sym_ready, bus.out_decoded, bus.out_error,
                         bus.out_uncorr, bus.out_timeout, ed, ee, eu, et);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        fexp = (fexp + 1) % 65536;
        checks++;
        if ({bus.out_valid, bus.sym_ready, bus.frame_count} !== {2'b01, 16'(fexp)}) begin
            errors++;
            $display("FAIL accept: valid=%0b sym_ready=%0b frame_count=%0d expected 0 1 %0d",
                     bus.out_valid, bus.sym_ready, bus.frame_count, fexp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.cfg_valid = 0; bus.cfg_state = '0; bus.cfg_input = '0; bus.cfg_next = '0;
        bus.cfg_out = '0; bus.reconfig = 0; bus.sym_valid = 0; bus.sym_data = '0;
        bus.err_limit = '0; bus.out_ready = 0;
        #23;
        checks++;
        if ({bus.dec_restart, bus.dec_enable, bus.cfg_ready, bus.sym_ready, bus.out_valid,
             bus.tables_valid, bus.frame_count} !== {6'b100000, 16'd0}) begin
            errors++;
            $display("FAIL reset_outputs: rst/en/cfgrdy/symrdy/valid/tv=%b fc=%0d expected 100000 0",
                     {bus.dec_restart, bus.dec_enable, bus.cfg_ready, bus.sym_ready,
                      bus.out_valid, bus.tables_valid}, bus.frame_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.cfg_ready, bus.dec_load, bus.dec_restart} !== 3'b101) begin
            errors++;
            $display("FAIL after_reset: cfg_ready/dec_load/dec_restart got %b expected 101",
                     {bus.cfg_ready, bus.dec_load, bus.dec_restart});
        end
    endtask

    task automatic test_config();
        program_tables();
    endtask

    task automatic test_frame_basic();
        run_frame(7'b1011000, -1, 0, 1, 0, -1);
    endtask

    task automatic test_frame_error();
        run_frame(7'b1011000, 2 * N + 1, 0, 1, 5, -1);
    endtask

    task automatic test_timeout();
        run_frame(7'b1011000, -1, 3, 99, 1, -1);
    endtask

    task automatic test_reconfig();
        bus.sym_valid = 1'b1;
        bus.sym_data  = 2'b11;
        bus.reconfig  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL reconfig_blocks_sym: sym_ready got %0b expected 0", bus.sym_ready);
        end
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.reconfig  = 1'b0;
        checks++;
        if ({bus.tables_valid, bus.cfg_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reconfig_to_cfg: tables_valid/cfg_ready got %b expected 01",
                     {bus.tables_valid, bus.cfg_ready});
        end
        program_tables();
        // reconfig in the middle of a frame must be ignored
        run_frame(7'b0110101, -1, 1, 2, 0, 3);
        checks++;
        if (bus.tables_valid !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_ignored: tables_valid got %0b expected 1", bus.tables_valid);
        end
    endtask

    task automatic test_random();
        bus.cfg_valid = 1'b1;
        for (int r = 0; r < 10; r++) begin
            int flip;
            bus.cfg_state = SW'($urandom);
            bus.cfg_next  = SW'($urandom);
            bus.cfg_out   = N'($urandom);
            flip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * N - 1)) : -1;
            run_frame(L'($urandom), flip, int'($urandom_range(0, 2)),
                      int'($urandom_range(1, TMO + 2)), int'($urandom_range(0, 3)), -1);
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int hs;
        bit seen = 0;
        core_lat = 1;
        send_frame(7'b1100101, -1, -1, hs);
        repeat (6) @(negedge clk);
        checks++;
        if ({bus.dec_enable, bus.dec_encoded} !== {1'b1, tx[4]}) begin
            errors++;
            $display("FAIL feed_idx4: enable=%0b encoded=%b expected 1 %b",
                     bus.dec_enable, bus.dec_encoded, tx[4]);
        end
        #1 reset_n = 1'b0;
        #1;
        fexp = 0;
        checks++;
        if ({bus.dec_restart, bus.dec_enable, bus.out_valid, bus.tables_valid, bus.frame_count}
            !== {4'b1000, 16'd0}) begin
            errors++;
            $display("FAIL async_reset: restart/en/valid/tv=%b fc=%0d expected 1000 0",
                     {bus.dec_restart, bus.dec_enable, bus.out_valid, bus.tables_valid},
                     bus.frame_count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.cfg_ready) seen = 1;
        end
        @(posedge clk); #1;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL discarded_frame: out_valid or left CFG got 1 expected 0");
        end
        program_tables();
        run_frame(7'b0001111, -1, 0, 1, 0, -1);
    endtask

    initial begin
        build_ref_tables();
        test_reset();
        test_config();
        test_frame_basic();
        test_frame_error();
        test_timeout();
        test_reconfig();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
